// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module : dmem_arbiter_pkg
// Brief  : Shared DMEM geometry defaults and arbiter owner-state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    localparam int unsigned c_DMEM_AW     = 7;
    localparam int unsigned c_DMEM_DW     = 16;
    localparam int unsigned c_MAX_HOLD    = 4;

    // Owner = master granted in the previous cycle (IDLE when nobody was).
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_grant.sv
// ============================================================================
// Module : dmem_arb_grant
// Brief  : Combinational round-robin grant decision with bounded owner hold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arb_grant
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = c_MAX_HOLD,
    parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic              i_req0,
    input  logic              i_req1,
    input  arb_state_t        i_owner,
    input  logic [HOLD_W-1:0] i_hold,
    input  logic              i_prio,
    output logic              o_gnt0,
    output logic              o_gnt1
);

    logic w_hold_left;

    assign w_hold_left = (i_hold < HOLD_W'(MAX_HOLD));

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            // Contention: owner keeps the port until its hold budget runs out.
            unique case (i_owner)
                ARB_OWN0: begin
                    o_gnt0 = w_hold_left;
                    o_gnt1 = !w_hold_left;
                end
                ARB_OWN1: begin
                    o_gnt1 = w_hold_left;
                    o_gnt0 = !w_hold_left;
                end
                default: begin
                    o_gnt1 = i_prio;
                    o_gnt0 = !i_prio;
                end
            endcase
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Two-master round-robin arbiter for the single-port 1-cycle DMEM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = c_DMEM_AW,
    parameter int unsigned DW       = c_DMEM_DW,
    parameter int unsigned MAX_HOLD = c_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int unsigned c_HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                r_prio;
    logic                w_prio_nxt;
    logic                r_rd_pend;
    logic                r_rd_owner;
    logic                w_raw_gnt0;
    logic                w_raw_gnt1;
    logic                w_gnt0;
    logic                w_gnt1;

    dmem_arb_grant #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (c_HOLD_W)
    ) u_grant (
        .i_req0  (i_m0_req),
        .i_req1  (i_m1_req),
        .i_owner (r_state),
        .i_hold  (r_hold),
        .i_prio  (r_prio),
        .o_gnt0  (w_raw_gnt0),
        .o_gnt1  (w_raw_gnt1)
    );

    // Requests can be high during reset; nothing may reach the memory then.
    assign w_gnt0   = w_raw_gnt0 & rst_n;
    assign w_gnt1   = w_raw_gnt1 & rst_n;
    assign o_m0_gnt = w_gnt0;
    assign o_m1_gnt = w_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_hold  <= '0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ARB_IDLE;
        w_hold_nxt  = '0;
        w_prio_nxt  = r_prio;
        if (w_gnt0) begin
            w_state_nxt = ARB_OWN0;
            w_prio_nxt  = 1'b1;
            if (r_state != ARB_OWN0) begin
                w_hold_nxt = c_HOLD_W'(1);
            end else if (r_hold < c_HOLD_W'(MAX_HOLD)) begin
                w_hold_nxt = r_hold + c_HOLD_W'(1);
            end else begin
                w_hold_nxt = r_hold;
            end
        end else if (w_gnt1) begin
            w_state_nxt = ARB_OWN1;
            w_prio_nxt  = 1'b0;
            if (r_state != ARB_OWN1) begin
                w_hold_nxt = c_HOLD_W'(1);
            end else if (r_hold < c_HOLD_W'(MAX_HOLD)) begin
                w_hold_nxt = r_hold + c_HOLD_W'(1);
            end else begin
                w_hold_nxt = r_hold;
            end
        end
    end

    always_comb begin
        o_mem_en    = w_gnt0 | w_gnt1;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_gnt0) begin
            o_mem_we    = i_m0_we;
            o_mem_addr  = i_m0_addr;
            o_mem_wdata = i_m0_wdata;
        end else if (w_gnt1) begin
            o_mem_we    = i_m1_we;
            o_mem_addr  = i_m1_addr;
            o_mem_wdata = i_m1_wdata;
        end
    end

    // Tag each read with its issuer so returning data goes to the right master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend  <= o_mem_en & ~o_mem_we;
            r_rd_owner <= w_gnt1;
        end
    end

    assign o_m0_rvalid = r_rd_pend & ~r_rd_owner;
    assign o_m1_rvalid = r_rd_pend &  r_rd_owner;
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Randomised and directed self-checking bench for dmem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int c_MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [6:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
    logic [15:0] o_m0_rdata, o_m1_rdata;
    logic        o_mem_en, o_mem_we;
    logic [6:0]  o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] mem    [128] = '{default: 16'h0};

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: who was granted last, how many times in a row, and
    // who wins the next tie; plus a shadow of memory contents.
    int          last_m  = -1;
    int          streak  = 0;
    int          pref    = 0;
    int          last_g  = -1;
    bit          exp_pv  = 1'b0;
    int          exp_pm  = 0;
    logic [15:0] exp_pd  = 16'h0;
    logic [15:0] shadow [128] = '{default: 16'h0};
    bit          p0, p1;

    always #5 clk = ~clk;

    dmem_arbiter u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_m0_req    (m0_req),
        .i_m0_we     (m0_we),
        .i_m0_addr   (m0_addr),
        .i_m0_wdata  (m0_wdata),
        .o_m0_gnt    (o_m0_gnt),
        .o_m0_rvalid (o_m0_rvalid),
        .o_m0_rdata  (o_m0_rdata),
        .i_m1_req    (m1_req),
        .i_m1_we     (m1_we),
        .i_m1_addr   (m1_addr),
        .i_m1_wdata  (m1_wdata),
        .o_m1_gnt    (o_m1_gnt),
        .o_m1_rvalid (o_m1_rvalid),
        .o_m1_rdata  (o_m1_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Single-port DMEM macro with one cycle of read latency.
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
            else          mem_rdata       <= mem[o_mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered just after a negedge with inputs applied; leaves at next negedge.
    task automatic tick(input bit rst_mid);
        int g;
        int wr;
        logic [6:0]  a;
        logic [15:0] d;
        #1;
        g = -1;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                if (last_m < 0)               g = pref;
                else if (streak < c_MAX_HOLD) g = last_m;
                else                          g = 1 - last_m;
            end else if (m0_req) g = 0;
            else if (m1_req)     g = 1;
        end
        wr = (g == 0) ? int'(m0_we) : (g == 1) ? int'(m1_we) : 0;
        a  = (g == 0) ? m0_addr  : (g == 1) ? m1_addr  : 7'd0;
        d  = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : 16'd0;
        chk("gnt",       {30'd0, o_m1_gnt, o_m0_gnt}, (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
        chk("mem_en",    32'(o_mem_en), (g >= 0) ? 32'd1 : 32'd0);
        chk("mem_we",    32'(o_mem_we), 32'(wr));
        chk("mem_addr",  32'(o_mem_addr), 32'(a));
        chk("mem_wdata", 32'(o_mem_wdata), 32'(d));
        chk("rvalid",    {30'd0, o_m1_rvalid, o_m0_rvalid},
            !exp_pv ? 32'd0 : (exp_pm == 1) ? 32'd2 : 32'd1);
        chk("m0_rdata",  32'(o_m0_rdata), (exp_pv && exp_pm == 0) ? 32'(exp_pd) : 32'd0);
        chk("m1_rdata",  32'(o_m1_rdata), (exp_pv && exp_pm == 1) ? 32'(exp_pd) : 32'd0);
        last_g = g;
        if (rst_mid) begin
            #1 rst_n = 1'b0;
            last_g = -1;
        end
        @(posedge clk);
        if (!rst_n) begin
            last_m = -1; streak = 0; pref = 0; exp_pv = 1'b0;
        end else begin
            exp_pv = (g >= 0) && (wr == 0);
            exp_pm = g;
            if (g >= 0 && wr == 0) exp_pd = shadow[a];
            if (g >= 0 && wr != 0) shadow[a] = d;
            if (g < 0) begin
                last_m = -1; streak = 0;
            end else begin
                streak = (g == last_m) ? ((streak < c_MAX_HOLD) ? streak + 1 : streak) : 1;
                last_m = g;
                pref   = 1 - g;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_m0(input bit req, input bit we, input int addr, input int data);
        m0_req = req; m0_we = we; m0_addr = 7'(addr); m0_wdata = 16'(data);
    endtask

    task automatic set_m1(input bit req, input bit we, input int addr, input int data);
        m1_req = req; m1_we = we; m1_addr = 7'(addr); m1_wdata = 16'(data);
    endtask

    initial begin
        rst_n = 1'b0;
        set_m0(1, 0, 0, 0);
        set_m1(1, 0, 0, 0);
        @(negedge clk);
        // Reset holds everything off even with both requesting.
        tick(0);
        tick(0);
        rst_n = 1'b1;
        #1 chk("first_gnt_m0", {30'd0, o_m1_gnt, o_m0_gnt}, 32'd1);
        tick(0);

        // Solo write then read-back by m0.
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        tick(0);
        set_m0(1, 1, 0, 16'h0004); tick(0);
        set_m0(1, 0, 0, 0);        tick(0);
        set_m0(0, 0, 0, 0);
        #1 chk("solo_rdata", {15'd0, o_m1_rvalid, o_m0_rdata}, 32'h0004 | 32'h0);
        chk("solo_rvalid", 32'(o_m0_rvalid), 32'd1);
        tick(0);

        // Read tagging across consecutive grants to alternating masters.
        set_m0(1, 1, 3, 16'h1111); tick(0);
        set_m0(0, 0, 0, 0); set_m1(1, 1, 5, 16'h2222); tick(0);
        set_m1(0, 0, 0, 0); set_m0(1, 0, 3, 0); tick(0);
        set_m0(0, 0, 0, 0); set_m1(1, 0, 5, 0); tick(0);
        set_m1(0, 0, 0, 0); tick(0);
        tick(0);

        // Sustained contention, then m1 joins after m0 has streamed.
        set_m0(1, 0, 1, 0); set_m1(1, 0, 2, 0);
        for (int i = 0; i < 14; i++) tick(0);
        set_m1(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0);
        set_m1(1, 1, 9, 16'hbeef);
        for (int i = 0; i < 6; i++) tick(0);
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        tick(0);

        // Reset arrives after a m1 read grant, before its data returns.
        set_m1(1, 0, 5, 0);
        tick(1);
        set_m1(0, 0, 0, 0);
        tick(0);
        rst_n = 1'b1;
        set_m0(1, 0, 3, 0); set_m1(1, 0, 5, 0);
        tick(0);
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        tick(0);

        // Randomised traffic: requests held until granted, occasional drops.
        p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1;
                set_m0(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom));
            end else if (p0 && $urandom_range(0, 15) == 0) begin
                p0 = 1'b0;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1;
                set_m1(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom));
            end else if (p1 && $urandom_range(0, 15) == 0) begin
                p1 = 1'b0;
            end
            m0_req = p0;
            m1_req = p1;
            tick(0);
            if (last_g == 0) p0 = 1'b0;
            if (last_g == 1) p1 = 1'b0;
        end
        set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        tick(0);
        tick(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
